// File: rtl/sample_mem_arbiter.sv
// Sample SDRAM port arbiter: one buffered download write beats round-robin voice byte reads.
// Latency: write issued the cycle after dl_wr; miss ack one cycle after mem_ack; hit ack one cycle after grant.
// Backpressure: dl_wait while the single write buffer is full; voices hold v_req/v_addr until v_ack.
//
// Ports: clk, reset (synchronous, active-high); dl_active/dl_wr/dl_addr/dl_data/dl_wait downloader side;
// v_req/v_addr/v_ack/v_byte voice read side; mem_addr/mem_rd/mem_we/mem_din/mem_dout/mem_ack controller side.
// Build option: define SAMPLE_ARB_CACHE_EN to give every voice a one-word read cache.
module sample_mem_arbiter #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dl_active,
    input  logic                         dl_wr,
    input  logic [ADDR_W-1:0]            dl_addr,
    input  logic [7:0]                   dl_data,
    output logic                         dl_wait,
    input  logic [NUM_VOICES-1:0]        v_req,
    input  logic [NUM_VOICES*ADDR_W-1:0] v_addr,
    output logic [NUM_VOICES-1:0]        v_ack,
    output logic [7:0]                   v_byte,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    output logic                         mem_we,
    output logic [7:0]                   mem_din,
    input  logic [15:0]                  mem_dout,
    input  logic                         mem_ack
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [NUM_VOICES-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;
    state_t state, state_nxt;

    logic [VW-1:0]     rr_ptr;
    logic [VW-1:0]     cur_idx;
    logic              cur_byte;
    logic              buf_vld;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    logic [ADDR_W-1:0] va [NUM_VOICES];
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_va
        assign va[gi] = v_addr[gi*ADDR_W +: ADDR_W];
    end

    // Round-robin search starting after the last grant. A voice whose ack is
    // on the wire this cycle is masked so it cannot be granted twice for one request.
    logic [NUM_VOICES-1:0] req_eff;
    logic                  hi_vld, lo_vld, gnt_vld;
    logic [VW-1:0]         hi_idx, lo_idx, gnt_idx;
    logic [ADDR_W-1:0]     gnt_addr;

    always_comb begin
        req_eff = v_req & ~v_ack & {NUM_VOICES{~dl_active}};
        hi_vld  = 1'b0;
        lo_vld  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (req_eff[i]) begin
                lo_vld = 1'b1;
                lo_idx = VW'(i);
                if (i > int'(rr_ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = VW'(i);
                end
            end
        end
        gnt_vld  = hi_vld | lo_vld;
        gnt_idx  = hi_vld ? hi_idx : lo_idx;
        gnt_addr = va[gnt_idx];
    end

    logic take_gnt, issue_wr, issue_rd, is_hit, rd_done, wr_done;
    logic hit;
    logic [7:0] hit_byte;

    // A buffered write always wins; a fresh dl_wr only bypasses straight to the
    // controller when no voice is being granted in the same cycle.
    always_comb begin
        take_gnt = (state == IDLE) && !buf_vld && gnt_vld;
        issue_wr = (state == IDLE) && (buf_vld || (dl_wr && !gnt_vld));
        is_hit   = take_gnt && hit;
        issue_rd = take_gnt && !hit;
        rd_done  = (state == RD_WAIT) && mem_ack;
        wr_done  = (state == WR_WAIT) && mem_ack;
    end

`ifdef SAMPLE_ARB_CACHE_EN
    logic              dl_active_q;
    logic              c_vld  [NUM_VOICES];
    logic [ADDR_W-2:0] c_addr [NUM_VOICES];
    logic [15:0]       c_data [NUM_VOICES];

    always_comb begin
        hit      = c_vld[gnt_idx] && (c_addr[gnt_idx] == gnt_addr[ADDR_W-1:1]);
        hit_byte = gnt_addr[0] ? c_data[gnt_idx][15:8] : c_data[gnt_idx][7:0];
    end

    // Invalidation on the start of a download beats a fill completing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_active_q <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
        end
        if (reset || (dl_active && !dl_active_q)) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                c_vld[i] <= 1'b0;
            end
        end else if (rd_done) begin
            c_vld[cur_idx]  <= 1'b1;
            c_addr[cur_idx] <= mem_addr[ADDR_W-1:1];
            c_data[cur_idx] <= mem_dout;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_byte = 8'h00;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_wr) begin
                    state_nxt = WR_WAIT;
                end else if (issue_rd) begin
                    state_nxt = RD_WAIT;
                end
            end
            WR_WAIT: if (mem_ack) state_nxt = IDLE;
            RD_WAIT: if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    logic                  mem_rd_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]     mem_addr_nxt;
    logic [7:0]            mem_din_nxt, v_byte_nxt;
    logic [NUM_VOICES-1:0] v_ack_nxt;

    always_comb begin
        mem_rd_nxt   = issue_rd;
        mem_we_nxt   = issue_wr;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        v_ack_nxt    = '0;
        v_byte_nxt   = v_byte;
        if (issue_wr) begin
            mem_addr_nxt = buf_vld ? buf_addr : dl_addr;
            mem_din_nxt  = buf_vld ? buf_data : dl_data;
        end else if (issue_rd) begin
            mem_addr_nxt = {gnt_addr[ADDR_W-1:1], 1'b0};
        end
        if (is_hit) begin
            v_ack_nxt  = ONE << gnt_idx;
            v_byte_nxt = hit_byte;
        end else if (rd_done) begin
            v_byte_nxt = cur_byte ? mem_dout[15:8] : mem_dout[7:0];
            // A voice that abandoned its request still lets the cycle finish, but gets no ack.
            if (v_req[cur_idx]) begin
                v_ack_nxt = ONE << cur_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= VW'(NUM_VOICES - 1);
            cur_idx  <= '0;
            cur_byte <= 1'b0;
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            v_ack    <= '0;
            v_byte   <= '0;
        end else begin
            if (take_gnt) begin
                rr_ptr   <= gnt_idx;
                cur_idx  <= gnt_idx;
                cur_byte <= gnt_addr[0];
            end
            if (wr_done) begin
                buf_vld <= 1'b0;
            end else if (dl_wr && !buf_vld) begin
                buf_vld  <= 1'b1;
                buf_addr <= dl_addr;
                buf_data <= dl_data;
            end
            mem_rd   <= mem_rd_nxt;
            mem_we   <= mem_we_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            v_ack    <= v_ack_nxt;
            v_byte   <= v_byte_nxt;
        end
    end

    assign dl_wait = buf_vld;

endmodule

// File: tb/tb_sample_mem_arbiter.sv
module tb_sample_mem_arbiter;
    localparam int NV = 4;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_active, dl_wr, dl_wait;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic [NV-1:0] v_req, v_ack;
    logic [NV*AW-1:0] v_addr;
    logic [7:0]    v_byte;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_we, mem_ack;
    logic [7:0]    mem_din;
    logic [15:0]   mem_dout;

    int n_tests = 0;
    int n_fail  = 0;

    sample_mem_arbiter #(.NUM_VOICES(NV), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
        .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_byte(v_byte),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        v_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        v_req = '0; v_addr = '0; mem_dout = '0; mem_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dl_wait"},  {31'd0, dl_wait},  32'd0);
        chk({tag, "_v_ack"},    {28'd0, v_ack},    32'd0);
        chk({tag, "_v_byte"},   {24'd0, v_byte},   32'd0);
        chk({tag, "_mem_rd"},   {31'd0, mem_rd},   32'd0);
        chk({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
        chk({tag, "_mem_addr"}, {7'd0, mem_addr},  32'd0);
        chk({tag, "_mem_din"},  {24'd0, mem_din},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        int          e;
        logic [7:0]  exp_b;

        // ---- reset values ----
        do_reset();
        chk_reset_outputs("reset");

        // ---- single miss: byte 0x101 -> upper byte of word 0x100 ----
        set_addr(0, 25'h000101); v_req = 4'b0001;
        step();
        chk("a_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("a_mem_addr", {7'd0, mem_addr}, 32'h100);
        step();
        chk("a_mem_rd_one_cycle", {31'd0, mem_rd}, 32'd0);
        step();
        chk("a_no_early_ack", {28'd0, v_ack}, 32'd0);
        mem_dout = 16'hBEEF; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; v_req = 4'b0000;
        chk("a_v_ack", {28'd0, v_ack}, 32'h1);
        chk("a_v_byte", {24'd0, v_byte}, 32'hBE);
        step();
        chk("a_ack_pulse", {28'd0, v_ack}, 32'd0);

        // ---- round robin with all voices requesting ----
        do_reset();
        for (int i = 0; i < NV; i++) set_addr(i, AW'(32'h1000 + i * 16 + (i & 1)));
        v_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e = g % NV;
            seen = 1'b0;
            for (int t = 0; t < 8 && !seen; t++) begin
                step();
                seen = mem_rd;
            end
            chk("rr_rd_seen", {31'd0, seen}, 32'd1);
            chk("rr_grant_addr", {7'd0, mem_addr}, 32'h1000 + e * 16);
            step();
            chk("rr_single_outstanding", {31'd0, mem_rd}, 32'd0);
            step();
            chk("rr_single_outstanding", {31'd0, mem_rd}, 32'd0);
            mem_dout = {8'hA0 + 8'(e), 8'h50 + 8'(e)}; mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            exp_b = (e & 1) ? 8'hA0 + 8'(e) : 8'h50 + 8'(e);
            chk("rr_v_ack", {28'd0, v_ack}, 32'd1 << e);
            chk("rr_v_byte", {24'd0, v_byte}, {24'd0, exp_b});
        end
        v_req = 4'b0000;
        step();

        // ---- download write arriving while voice 2 is in RD_WAIT ----
        do_reset();
        set_addr(2, 25'h000300); v_req = 4'b0100;
        step();
        chk("c_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("c_mem_addr", {7'd0, mem_addr}, 32'h300);
        dl_wr = 1'b1; dl_addr = 25'h40; dl_data = 8'h5A;
        step();
        dl_wr = 1'b0;
        chk("c_dl_wait_set", {31'd0, dl_wait}, 32'd1);
        chk("c_no_we_during_rd", {31'd0, mem_we}, 32'd0);
        step();
        mem_dout = 16'h1234; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; v_req = 4'b0000;
        chk("c_v_ack_first", {28'd0, v_ack}, 32'h4);
        chk("c_v_byte", {24'd0, v_byte}, 32'h34);
        chk("c_no_we_yet", {31'd0, mem_we}, 32'd0);
        step();
        chk("c_mem_we", {31'd0, mem_we}, 32'd1);
        chk("c_we_addr", {7'd0, mem_addr}, 32'h40);
        chk("c_we_din", {24'd0, mem_din}, 32'h5A);
        step();
        chk("c_we_one_cycle", {31'd0, mem_we}, 32'd0);
        chk("c_dl_wait_held", {31'd0, dl_wait}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("c_dl_wait_clear", {31'd0, dl_wait}, 32'd0);

        // ---- direct write from IDLE, plus a strobe while full is dropped ----
        dl_wr = 1'b1; dl_addr = 25'h41; dl_data = 8'hA5;
        step();
        dl_wr = 1'b1; dl_addr = 25'h99; dl_data = 8'h77;
        chk("w_mem_we_next", {31'd0, mem_we}, 32'd1);
        chk("w_addr", {7'd0, mem_addr}, 32'h41);
        chk("w_din", {24'd0, mem_din}, 32'hA5);
        chk("w_dl_wait", {31'd0, dl_wait}, 32'd1);
        step();
        dl_wr = 1'b0;
        chk("w_we_one_cycle", {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("w_dl_wait_clear", {31'd0, dl_wait}, 32'd0);
        step();
        chk("w_dropped_no_we", {31'd0, mem_we}, 32'd0);
        chk("w_dropped_no_wait", {31'd0, dl_wait}, 32'd0);

        // ---- voice held off while dl_active ----
        do_reset();
        dl_active = 1'b1; set_addr(1, 25'h000500); v_req = 4'b0010;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("d_no_rd_active", {31'd0, mem_rd}, 32'd0);
            chk("d_no_ack_active", {28'd0, v_ack}, 32'd0);
        end
        dl_active = 1'b0;
        step();
        chk("d_rd_after_fall", {31'd0, mem_rd}, 32'd1);
        chk("d_rd_addr", {7'd0, mem_addr}, 32'h500);
        step();
        mem_dout = 16'h7788; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; v_req = 4'b0000;
        chk("d_v_ack", {28'd0, v_ack}, 32'h2);
        chk("d_v_byte", {24'd0, v_byte}, 32'h88);

        // ---- two bytes of one word ----
        do_reset();
        set_addr(0, 25'h000200); v_req = 4'b0001;
        step();
        chk("e_first_rd", {31'd0, mem_rd}, 32'd1);
        step();
        mem_dout = 16'hC3D4; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; v_req = 4'b0000;
        chk("e_first_byte", {24'd0, v_byte}, 32'hD4);
        step();
        set_addr(0, 25'h000201); v_req = 4'b0001;
        step();
`ifdef SAMPLE_ARB_CACHE_EN
        v_req = 4'b0000;
        chk("e_hit_no_rd", {31'd0, mem_rd}, 32'd0);
        chk("e_hit_ack", {28'd0, v_ack}, 32'h1);
        chk("e_hit_byte", {24'd0, v_byte}, 32'hC3);
        step();
        dl_active = 1'b1;
        step();
        dl_active = 1'b0;
        step();
        v_req = 4'b0001;
        step();
        chk("e_inval_miss_rd", {31'd0, mem_rd}, 32'd1);
        chk("e_inval_miss_addr", {7'd0, mem_addr}, 32'h200);
`else
        chk("e_second_rd", {31'd0, mem_rd}, 32'd1);
        chk("e_second_addr", {7'd0, mem_addr}, 32'h200);
        chk("e_no_early_ack", {28'd0, v_ack}, 32'd0);
`endif
        step();
        mem_dout = 16'hC3D4; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; v_req = 4'b0000;
        chk("e_second_ack", {28'd0, v_ack}, 32'h1);
        chk("e_second_byte", {24'd0, v_byte}, 32'hC3);

        // ---- reset during RD_WAIT, then a late ack ----
        do_reset();
        set_addr(0, 25'h000600); v_req = 4'b0001;
        step();
        chk("f_rd", {31'd0, mem_rd}, 32'd1);
        step();
        reset = 1'b1;
        step();
        chk_reset_outputs("f_reset");
        reset = 1'b0; v_req = 4'b0000; mem_dout = 16'hFFFF; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("f_late_no_ack", {28'd0, v_ack}, 32'd0);
        chk("f_late_byte", {24'd0, v_byte}, 32'd0);
        chk("f_late_no_rd", {31'd0, mem_rd}, 32'd0);
        set_addr(0, 25'h000601); v_req = 4'b0001;
        step();
        chk("f_fresh_rd", {31'd0, mem_rd}, 32'd1);
        chk("f_fresh_addr", {7'd0, mem_addr}, 32'h600);
        step();
        mem_dout = 16'h1122; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; v_req = 4'b0000;
        chk("f_fresh_ack", {28'd0, v_ack}, 32'h1);
        chk("f_fresh_byte", {24'd0, v_byte}, 32'h11);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_mem_arbiter.md
# sample_mem_arbiter

Arbitrates the single SDRAM port used for sample storage between the ROM/sample download writer and NUM_VOICES sample-playback read requesters. Download writes always win. Voice reads are served round-robin, returning the addressed byte of a 16-bit SDRAM word. It sits between the downloader/sample voices and the `sdram` controller, in the SDRAM clock domain.

## Interface
Parameters:
- NUM_VOICES, 4, number of read requesters (2..8)
- ADDR_W, 25, byte address width

Ports:
- clk  in  1  SDRAM-domain clock
- reset  in  1  synchronous, active-high
- dl_active  in  1  download in progress; voice service suspended while high
- dl_wr  in  1  one-cycle write strobe
- dl_addr  in  ADDR_W  write byte address
- dl_data  in  8  write byte
- dl_wait  out  1  write buffer occupied; downloader must not strobe dl_wr
- v_req  in  NUM_VOICES  per-voice level read request
- v_addr  in  NUM_VOICES*ADDR_W  per-voice byte address; voice i at [i*ADDR_W +: ADDR_W]
- v_ack  out  NUM_VOICES  one-cycle per-voice completion pulse
- v_byte  out  8  returned byte; valid only in the v_ack cycle
- mem_addr  out  ADDR_W  to controller; word-aligned (bit 0 forced 0) for reads, byte address for writes
- mem_rd  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_din  out  8  write data
- mem_dout  in  16  read word; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion from the controller, for reads and writes

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT.
- Write buffer holds one entry.
  - dl_wr loads dl_addr and dl_data into the buffer and sets dl_wait.
  - dl_wr while the buffer is full is dropped.
- IDLE decision priority:
  1. A buffered write: issue mem_we and go to WR_WAIT.
  2. Otherwise, if dl_active is low, grant the first requesting voice searching round-robin from (last granted + 1) mod NUM_VOICES.
- On a voice grant:
  - Cache hit: ack with no memory access.
  - Miss: issue mem_rd with {v_addr[ADDR_W-1:1],1'b0} and go to RD_WAIT.
- WR_WAIT: on mem_ack, clear the buffer, drop dl_wait, and return to IDLE.
- RD_WAIT: on mem_ack:
  - Select the byte: v_addr[0]=0 gives mem_dout[7:0]; 1 gives [15:8].
  - Pulse v_ack[grant] with v_byte.
  - Update that voice's cache (when enabled).
  - Return to IDLE.
- The round-robin pointer updates on every grant, hit or miss.
- A voice must hold v_req and v_addr stable until its v_ack.
  - If v_req drops after grant, the memory cycle still completes and the cache is updated, but v_ack is suppressed.
  - If v_req drops before grant, it is simply never granted.
- A rising edge of dl_active invalidates all voice caches. The stored data changes during a download.
- Voice requests pending while dl_active is high are held, not acked. Service resumes in the first IDLE cycle after dl_active falls.
- Only one memory operation is outstanding at a time.

## Timing
- All outputs are registered. Reset values:
  - dl_wait=0, v_ack=0, v_byte=0, mem_rd=0, mem_we=0, mem_addr=0, mem_din=0.
  - State IDLE; round-robin pointer NUM_VOICES-1, so voice 0 has first priority.
  - Write buffer empty; caches invalid.
- dl_wr in cycle N: dl_wait high from N+1.
  - If IDLE, mem_we is high in N+1 only.
  - mem_ack in cycle M: dl_wait low from M+1.
- Read miss granted in IDLE cycle N: mem_rd high in N+1 only.
  - mem_ack in cycle M: v_ack and v_byte in M+1; FSM is IDLE in M+1.
  - Next grant is evaluated in M+1.
- Cache hit granted in cycle N: v_ack in N+1. Back-to-back hits give one ack per 2 cycles.
- dl_wr in the same cycle as a pending voice grant: the voice grant proceeds and the write is buffered for the next IDLE.
- Reset mid-operation:
  - Abort to IDLE, clear the buffer, invalidate caches.
  - A late mem_ack while IDLE is ignored.

## Configuration
- SAMPLE_ARB_CACHE_EN defined:
  - Each voice keeps a one-word cache: valid bit, word address ADDR_W-1 bits, 16-bit data.
  - A grant whose v_addr[ADDR_W-1:1] matches the cached word address, with valid set, is a hit.
- SAMPLE_ARB_CACHE_EN undefined:
  - No cache storage.
  - Every grant is a memory read, so consecutive bytes of one word cost two memory cycles.

## Test plan
- Reset, then v_req[0] at addr 0x000101, controller returns mem_dout=0xBEEF at mem_ack -> mem_addr=0x000100, v_ack[0] with v_byte=0xBE, one cycle after mem_ack.
- v_req=4'b1111 held, controller acks each read after 3 cycles -> grants in order 0,1,2,3,0; no voice starves; exactly one mem_rd outstanding at a time.
- dl_wr to 0x40 with data 0x5A while voice 2 is in RD_WAIT -> voice 2 acks first; mem_we with mem_addr=0x40 and mem_din=0x5A follows; dl_wait high from the cycle after dl_wr until the cycle after the write ack.
- dl_active high with v_req[1] pending -> no mem_rd and no v_ack[1] until dl_active falls; then v_ack[1] is delivered.
- With SAMPLE_ARB_CACHE_EN: voice 0 reads 0x200, then 0x201 -> second access produces no mem_rd; v_ack in the cycle after the grant with the upper byte.
  - Without the macro: two mem_rd strobes.
  - With the macro, after a dl_active pulse: a read of 0x201 misses.
- Assert reset while in RD_WAIT, then a late mem_ack -> no v_ack; all outputs hold reset values; the next request behaves as a fresh miss.
